// File: rtl/timing_generator_multi.sv
// Multi-channel frame timing generator with an AXI4-Lite register file.
// Frame timer, frame counter, frame-start strobe and TRIG_NUM shadowed trigger windows.
module timing_generator_multi #(
  parameter logic [31:0]     CORE_ID           = 32'haaaa_1235,
  parameter logic [31:0]     CORE_VERSION      = 32'h0002_0000,
  parameter int              TIMER_BITS        = 32,
  parameter int              FRAMES_BITS       = 32,
  parameter int              REGADR_BITS       = 8,
  parameter int              TRIG_NUM          = 4,
  parameter int              DATA_BITS         = 32,
  parameter logic [3:0]      INIT_CTL_CONTROL  = 4'b0000,
  parameter logic [TIMER_BITS-1:0] INIT_PARAM_PERIOD = 100000,
  parameter logic [TIMER_BITS-1:0] INIT_TRIG_START   = 1,
  parameter logic [TIMER_BITS-1:0] INIT_TRIG_END     = 90000,
  parameter logic            INIT_TRIG_POL     = 1'b0,
  parameter logic            INIT_TRIG_EN      = 1'b1
) (
  input  logic                     s_axi4l_aclk,
  input  logic                     s_axi4l_aresetn,
  input  logic [REGADR_BITS+1:0]   s_axi4l_awaddr,
  input  logic                     s_axi4l_awvalid,
  output logic                     s_axi4l_awready,
  input  logic [DATA_BITS-1:0]     s_axi4l_wdata,
  input  logic [DATA_BITS/8-1:0]   s_axi4l_wstrb,
  input  logic                     s_axi4l_wvalid,
  output logic                     s_axi4l_wready,
  output logic [1:0]               s_axi4l_bresp,
  output logic                     s_axi4l_bvalid,
  input  logic                     s_axi4l_bready,
  input  logic [REGADR_BITS+1:0]   s_axi4l_araddr,
  input  logic                     s_axi4l_arvalid,
  output logic                     s_axi4l_arready,
  output logic [DATA_BITS-1:0]     s_axi4l_rdata,
  output logic [1:0]               s_axi4l_rresp,
  output logic                     s_axi4l_rvalid,
  input  logic                     s_axi4l_rready,
  input  logic                     in_sync,
  output logic [TRIG_NUM-1:0]      out_trig,
  output logic                     out_frame_start,
  output logic [FRAMES_BITS-1:0]   out_frames
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_WAIT} state_t;

  localparam logic [REGADR_BITS-1:0] ADR_CORE_ID = 'h00, ADR_VERSION = 'h01, ADR_CTL = 'h04,
                                     ADR_STATUS  = 'h05, ADR_TIMER   = 'h08, ADR_FRAMES = 'h09,
                                     ADR_PERIOD  = 'h10;
  localparam int ADR_TRIG = 'h20;
  localparam int CTL_ENABLE = 0, CTL_UPDATE = 1, CTL_ONESHOT = 2, CTL_EXT_SYNC = 3;

  logic clk, rst_n;
  assign clk   = s_axi4l_aclk;
  assign rst_n = s_axi4l_aresetn;

  state_t                  state_q, state_d;
  logic [3:0]              ctl_q, ctl_d;
  logic                    overrun_q, overrun_d, sync_q;
  logic [TIMER_BITS-1:0]   timer_q, timer_d, period_q, period_d, period_act_q, period_act_d;
  logic [FRAMES_BITS-1:0]  frames_q, frames_d;
  logic [TIMER_BITS-1:0]   trig_start_q [TRIG_NUM], trig_start_d [TRIG_NUM];
  logic [TIMER_BITS-1:0]   trig_end_q [TRIG_NUM], trig_end_d [TRIG_NUM];
  logic [TIMER_BITS-1:0]   start_act_q [TRIG_NUM], start_act_d [TRIG_NUM];
  logic [TIMER_BITS-1:0]   end_act_q [TRIG_NUM], end_act_d [TRIG_NUM];
  logic [TRIG_NUM-1:0]     pol_q, pol_d, en_q, en_d, en_act_q, en_act_d;
  logic [TRIG_NUM-1:0]     trig_raw_q, trig_raw_d;
  logic                    frame_start_q, frame_start_d;
  logic                    bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [DATA_BITS-1:0]    rdata_q, rdata_d, rd_val;
  logic [REGADR_BITS-1:0]  wr_adr, rd_adr;
  logic                    wr_en, rd_en, sync_rise, frame_end, apply_update;
  logic                    unused_addr_bits;

  function automatic logic [DATA_BITS-1:0] wr_merge(input logic [DATA_BITS-1:0] old_val,
                                                    input logic [DATA_BITS-1:0] data,
                                                    input logic [DATA_BITS/8-1:0] strb);
    logic [DATA_BITS-1:0] r;
    r = old_val;
    for (int i = 0; i < DATA_BITS / 8; i++) if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

  assign wr_adr           = s_axi4l_awaddr[REGADR_BITS+1:2];
  assign rd_adr           = s_axi4l_araddr[REGADR_BITS+1:2];
  assign unused_addr_bits = ^{s_axi4l_awaddr[1:0], s_axi4l_araddr[1:0]};
  assign wr_en            = (~bvalid_q | s_axi4l_bready) & s_axi4l_awvalid & s_axi4l_wvalid;
  assign s_axi4l_awready  = wr_en;
  assign s_axi4l_wready   = wr_en;
  assign s_axi4l_arready  = ~rvalid_q | s_axi4l_rready;
  assign rd_en            = s_axi4l_arvalid & s_axi4l_arready;
  assign s_axi4l_bresp    = 2'b00;
  assign s_axi4l_rresp    = 2'b00;
  assign s_axi4l_bvalid   = bvalid_q;
  assign s_axi4l_rvalid   = rvalid_q;
  assign s_axi4l_rdata    = rdata_q;

  assign sync_rise    = in_sync & ~sync_q;
  assign frame_end    = (state_q == ST_RUN) && (timer_q == period_act_q);
  // Shadows load at a frame boundary, or at once whenever no frame is in flight.
  assign apply_update = ctl_q[CTL_UPDATE] && ((state_q != ST_RUN) || frame_end);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (ctl_q[CTL_ENABLE] && (!ctl_q[CTL_EXT_SYNC] || sync_rise)) state_d = ST_RUN;
      ST_RUN: begin
        if (frame_end) begin
          if (!ctl_q[CTL_ENABLE] || ctl_q[CTL_ONESHOT]) state_d = ST_IDLE;
          else if (ctl_q[CTL_EXT_SYNC])                 state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!ctl_q[CTL_ENABLE]) state_d = ST_IDLE;
        else if (sync_rise)     state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    timer_d       = (state_q == ST_RUN && !frame_end) ? timer_q + 1'b1 : '0;
    frames_d      = frame_end ? frames_q + 1'b1 : frames_q;
    frame_start_d = (state_d == ST_RUN) && (timer_d == '0);
    for (int n = 0; n < TRIG_NUM; n++) begin
      trig_raw_d[n] = (state_q == ST_RUN) && en_act_q[n] &&
                      (start_act_q[n] <= timer_q) && (timer_q < end_act_q[n]);
    end
  end

  // NOTE: every variable gets its hold value first so no path through this block infers a latch.
  always_comb begin
    ctl_d = ctl_q;          overrun_d = overrun_q;      period_d = period_q;
    trig_start_d = trig_start_q;  trig_end_d = trig_end_q;  pol_d = pol_q;  en_d = en_q;
    period_act_d = period_act_q;  start_act_d = start_act_q; end_act_d = end_act_q;
    en_act_d = en_act_q;
    if (apply_update) begin
      period_act_d = period_q;  start_act_d = trig_start_q;
      end_act_d = trig_end_q;   en_act_d = en_q;
      ctl_d[CTL_UPDATE] = 1'b0;
    end
    if (frame_end && ctl_q[CTL_ONESHOT]) ctl_d[CTL_ENABLE] = 1'b0;
    // A bus write lands after the hardware clears, so a freshly written update bit survives.
    if (wr_en) begin
      if (wr_adr == ADR_CTL)
        ctl_d = 4'(wr_merge(DATA_BITS'(ctl_q), s_axi4l_wdata, s_axi4l_wstrb));
      if (wr_adr == ADR_STATUS && s_axi4l_wstrb[0] && s_axi4l_wdata[2]) overrun_d = 1'b0;
      if (wr_adr == ADR_PERIOD)
        period_d = TIMER_BITS'(wr_merge(DATA_BITS'(period_q), s_axi4l_wdata, s_axi4l_wstrb));
      for (int n = 0; n < TRIG_NUM; n++) begin
        if (wr_adr == REGADR_BITS'(ADR_TRIG + 4*n))
          trig_start_d[n] = TIMER_BITS'(wr_merge(DATA_BITS'(trig_start_q[n]), s_axi4l_wdata,
                                                 s_axi4l_wstrb));
        if (wr_adr == REGADR_BITS'(ADR_TRIG + 4*n + 1))
          trig_end_d[n] = TIMER_BITS'(wr_merge(DATA_BITS'(trig_end_q[n]), s_axi4l_wdata,
                                               s_axi4l_wstrb));
        if (wr_adr == REGADR_BITS'(ADR_TRIG + 4*n + 2) && s_axi4l_wstrb[0]) pol_d[n] = s_axi4l_wdata[0];
        if (wr_adr == REGADR_BITS'(ADR_TRIG + 4*n + 3) && s_axi4l_wstrb[0]) en_d[n]  = s_axi4l_wdata[0];
      end
    end
    if (sync_rise && state_q == ST_RUN) overrun_d = 1'b1;
  end

  always_comb begin
    rd_val = '0;
    case (rd_adr)
      ADR_CORE_ID: rd_val = DATA_BITS'(CORE_ID);
      ADR_VERSION: rd_val = DATA_BITS'(CORE_VERSION);
      ADR_CTL:     rd_val = DATA_BITS'(ctl_q);
      ADR_STATUS:  rd_val = DATA_BITS'({overrun_q, ctl_q[CTL_UPDATE], state_q != ST_IDLE});
      ADR_TIMER:   rd_val = DATA_BITS'(timer_q);
      ADR_FRAMES:  rd_val = DATA_BITS'(frames_q);
      ADR_PERIOD:  rd_val = DATA_BITS'(period_q);
      default:     rd_val = '0;
    endcase
    for (int n = 0; n < TRIG_NUM; n++) begin
      if (rd_adr == REGADR_BITS'(ADR_TRIG + 4*n))     rd_val = DATA_BITS'(trig_start_q[n]);
      if (rd_adr == REGADR_BITS'(ADR_TRIG + 4*n + 1)) rd_val = DATA_BITS'(trig_end_q[n]);
      if (rd_adr == REGADR_BITS'(ADR_TRIG + 4*n + 2)) rd_val = DATA_BITS'(pol_q[n]);
      if (rd_adr == REGADR_BITS'(ADR_TRIG + 4*n + 3)) rd_val = DATA_BITS'(en_q[n]);
    end
    bvalid_d = wr_en | (bvalid_q & ~s_axi4l_bready);
    rvalid_d = rd_en | (rvalid_q & ~s_axi4l_rready);
    rdata_d  = rd_en ? rd_val : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q <= INIT_CTL_CONTROL;  overrun_q <= 1'b0;  sync_q <= 1'b0;
      timer_q <= '0;  frames_q <= '0;  period_q <= INIT_PARAM_PERIOD;  period_act_q <= INIT_PARAM_PERIOD;
      pol_q <= {TRIG_NUM{INIT_TRIG_POL}};  en_q <= {TRIG_NUM{INIT_TRIG_EN}};
      en_act_q <= {TRIG_NUM{INIT_TRIG_EN}};
      trig_raw_q <= '0;  frame_start_q <= 1'b0;
      bvalid_q <= 1'b0;  rvalid_q <= 1'b0;  rdata_q <= '0;
      // NOTE: these arrays are plain registers, not RAM, so each entry takes its reset value.
      for (int n = 0; n < TRIG_NUM; n++) begin
        trig_start_q[n] <= INIT_TRIG_START;  trig_end_q[n] <= INIT_TRIG_END;
        start_act_q[n]  <= INIT_TRIG_START;  end_act_q[n]  <= INIT_TRIG_END;
      end
    end else begin
      ctl_q <= ctl_d;  overrun_q <= overrun_d;  sync_q <= in_sync;
      timer_q <= timer_d;  frames_q <= frames_d;  period_q <= period_d;  period_act_q <= period_act_d;
      pol_q <= pol_d;  en_q <= en_d;  en_act_q <= en_act_d;
      trig_raw_q <= trig_raw_d;  frame_start_q <= frame_start_d;
      bvalid_q <= bvalid_d;  rvalid_q <= rvalid_d;  rdata_q <= rdata_d;
      trig_start_q <= trig_start_d;  trig_end_q <= trig_end_d;
      start_act_q  <= start_act_d;   end_act_q  <= end_act_d;
    end
  end

  // Polarity is applied live so it can be flipped without waiting for a frame boundary.
  assign out_trig        = trig_raw_q ^ pol_q;
  assign out_frame_start = frame_start_q;
  assign out_frames      = frames_q;

endmodule

// File: tb/tb_timing_generator_multi.sv
// Directed self-checking bench for timing_generator_multi: timing, shadowing, ext sync,
// overrun, async reset and AXI4-Lite back-pressure.
module tb_timing_generator_multi;

  localparam int A_CTL = 'h04, A_STATUS = 'h05, A_TIMER = 'h08, A_FRAMES = 'h09, A_PERIOD = 'h10;
  localparam int A_START0 = 'h20, A_END0 = 'h21, A_START1 = 'h24, A_POL1 = 'h26, A_EN1 = 'h27;

  logic        clk = 1'b0, rst_n = 1'b1;
  logic [9:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        in_sync = 1'b0;
  logic [3:0]  out_trig;
  logic        out_frame_start;
  logic [31:0] out_frames;

  int checks = 0, errors = 0, fs_count = 0;

  always #5 clk = ~clk;

  timing_generator_multi dut (
    .s_axi4l_aclk(clk), .s_axi4l_aresetn(rst_n),
    .s_axi4l_awaddr(awaddr), .s_axi4l_awvalid(awvalid), .s_axi4l_awready(awready),
    .s_axi4l_wdata(wdata), .s_axi4l_wstrb(wstrb), .s_axi4l_wvalid(wvalid), .s_axi4l_wready(wready),
    .s_axi4l_bresp(bresp), .s_axi4l_bvalid(bvalid), .s_axi4l_bready(bready),
    .s_axi4l_araddr(araddr), .s_axi4l_arvalid(arvalid), .s_axi4l_arready(arready),
    .s_axi4l_rdata(rdata), .s_axi4l_rresp(rresp), .s_axi4l_rvalid(rvalid), .s_axi4l_rready(rready),
    .in_sync(in_sync), .out_trig(out_trig), .out_frame_start(out_frame_start), .out_frames(out_frames)
  );

  // Independent count of frame-start pulses since the last reset.
  always @(negedge clk) begin
    if (!rst_n)               fs_count <= 0;
    else if (out_frame_start) fs_count <= fs_count + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input int wadr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    @(posedge clk); #1;
    awaddr = 10'(wadr * 4); wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 20) begin @(negedge clk); n++; end
    if (!awready) check("aw_timeout", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    if (!bvalid) check("b_timeout", bvalid, 1);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input int radr, output logic [31:0] data);
    int n;
    @(posedge clk); #1;
    araddr = 10'(radr * 4); arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 20) begin @(negedge clk); n++; end
    if (!arready) check("ar_timeout", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    if (!rvalid) check("r_timeout", rvalid, 1);
    data = rdata;
    @(posedge clk); #1;
  endtask

  task automatic read_check(input string tag, input int radr, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(radr, d);
    check(tag, d, exp);
  endtask

  // Aligns on a frame start (PERIOD=9 assumed) and counts ch0 highs over that frame.
  task automatic measure_frame(input string tag, output int highs, output int first_k);
    int n, extra;
    n = 0; extra = 0; highs = 0; first_k = -1;
    @(negedge clk);
    while (!out_frame_start && n < 40) begin @(negedge clk); n++; end
    check({tag, "_fs_seen"}, out_frame_start, 1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      if (out_trig[0]) begin highs++; if (first_k < 0) first_k = k; end
      if (k > 0 && out_frame_start) extra++;
    end
    check({tag, "_fs_gap"}, extra, 0);
    @(negedge clk);
    check({tag, "_fs_next"}, out_frame_start, 1);
  endtask

  task automatic sync_pulse();
    @(posedge clk); #1; in_sync = 1'b1;
    @(posedge clk); #1; in_sync = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int h, f, fs0, ones, zeros;
    logic [31:0] fr0;
    #2 rst_n = 1'b0;
    #20;
    check("rst_trig", out_trig, 0);
    check("rst_fs", out_frame_start, 0);
    check("rst_frames", out_frames, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    @(negedge clk); rst_n = 1'b1;
    read_check("core_id", 'h00, 32'haaaa_1235);
    read_check("version", 'h01, 32'h0002_0000);
    read_check("init_ctl", A_CTL, 0);
    read_check("init_period", A_PERIOD, 100000);
    read_check("init_start0", A_START0, 1);
    read_check("init_end0", A_END0, 90000);
    read_check("unmapped", 'h30, 0);

    // 1: free-running, 10-cycle frames, ch0 window 2..5 -> 3 highs, 1-cycle latency
    axi_write(A_PERIOD, 9, 4'hf);
    axi_write(A_START0, 2, 4'hf);
    axi_write(A_END0, 5, 4'hf);
    axi_write(A_CTL, 32'h3, 4'hf);
    measure_frame("t1", h, f);
    check("t1_highs", h, 3);
    check("t1_first", f, 3);
    measure_frame("t1b", h, f);
    check("t1b_highs", h, 3);
    axi_write(A_CTL, 0, 4'hf);
    cycles(15);
    check("t1_frames", out_frames, fs_count);
    read_check("t1_status", A_STATUS, 0);
    read_check("t1_timer", A_TIMER, 0);

    // 2: oneshot runs exactly one frame
    fr0 = out_frames; fs0 = fs_count;
    axi_write(A_CTL, 32'h5, 4'hf);
    cycles(25);
    check("t2_frames", out_frames, fr0 + 1);
    check("t2_fs", fs_count, fs0 + 1);
    read_check("t2_frames_reg", A_FRAMES, fr0 + 1);
    read_check("t2_ctl", A_CTL, 32'h4);
    read_check("t2_status", A_STATUS, 0);
    @(negedge clk); check("t2_trig_idle", out_trig[0], 0);
    axi_write(A_CTL, 0, 4'hf);

    // 3: external sync, PERIOD=4, overrun sticky + W1C
    axi_write(A_PERIOD, 4, 4'hf);
    axi_write(A_CTL, 32'hB, 4'hf);
    cycles(3);
    read_check("t3_wait_sync", A_STATUS, 0);
    fr0 = out_frames; fs0 = fs_count;
    sync_pulse();
    cycles(15);
    check("t3_one_frame", fs_count, fs0 + 1);
    read_check("t3_status_wait", A_STATUS, 32'h1);
    sync_pulse();
    @(posedge clk); #1; in_sync = 1'b1;
    @(posedge clk); #1; in_sync = 1'b0;
    cycles(15);
    check("t3_two_frames", fs_count, fs0 + 2);
    check("t3_frames", out_frames, fr0 + 2);
    read_check("t3_overrun", A_STATUS, 32'h5);
    axi_write(A_STATUS, 32'h4, 4'hf);
    read_check("t3_w1c", A_STATUS, 32'h1);
    axi_write(A_CTL, 0, 4'hf);
    read_check("t3_idle", A_STATUS, 0);

    // 4: shadowed window only changes after update
    axi_write(A_PERIOD, 9, 4'hf);
    axi_write(A_CTL, 32'h3, 4'hf);
    axi_write(A_START0, 6, 4'hf);
    axi_write(A_END0, 8, 4'hf);
    measure_frame("t4_old", h, f);
    check("t4_old_highs", h, 3);
    check("t4_old_first", f, 3);
    axi_write(A_CTL, 32'h3, 4'hf);
    cycles(12);
    read_check("t4_update_clr", A_CTL, 32'h1);
    measure_frame("t4_new", h, f);
    check("t4_new_highs", h, 2);
    check("t4_new_first", f, 7);
    axi_write(A_START0, 8, 4'hf);
    axi_write(A_CTL, 32'h3, 4'hf);
    cycles(12);
    measure_frame("t4_empty", h, f);
    check("t4_empty_highs", h, 0);

    // 5: live polarity on a disabled channel, then async reset mid-frame
    axi_write(A_POL1, 1, 4'hf);
    axi_write(A_EN1, 0, 4'hf);
    axi_write(A_CTL, 32'h3, 4'hf);
    cycles(15);
    ones = 0; zeros = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_trig[1]) ones++;
      if (!out_trig[0]) zeros++;
    end
    check("t5_pol1_const", ones, 12);
    check("t5_ch0_empty", zeros, 12);
    check("t5_frames_nz", out_frames != 0, 1);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    check("t5_rst_trig", out_trig, 0);
    check("t5_rst_fs", out_frame_start, 0);
    check("t5_rst_frames", out_frames, 0);
    #20; @(negedge clk); rst_n = 1'b1;
    read_check("t5_ctl", A_CTL, 0);
    read_check("t5_period", A_PERIOD, 100000);
    read_check("t5_pol1", A_POL1, 0);
    read_check("t5_en1", A_EN1, 1);

    // 6: write back-pressure and split address/data
    @(posedge clk); #1;
    bready = 1'b0; awaddr = 10'(A_PERIOD * 4); wdata = 7; wstrb = 4'hf; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk); check("t6_first_ready", awready, 1);
    @(posedge clk); #1; awaddr = 10'(A_START0 * 4); wdata = 3;
    @(negedge clk); check("t6_bvalid", bvalid, 1); check("t6_stall", awready, 0);
    @(posedge clk); #1;
    @(negedge clk); check("t6_stall2", wready, 0);
    bready = 1'b1; #1;
    check("t6_release", awready, 1);
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk); check("t6_bvalid2", bvalid, 1); check("t6_bresp", bresp, 0);
    @(posedge clk); #1;
    read_check("t6_period", A_PERIOD, 7);
    read_check("t6_start0", A_START0, 3);
    @(posedge clk); #1; awaddr = 10'(A_START1 * 4); wdata = 32'h55; awvalid = 1'b1; wvalid = 1'b0;
    @(negedge clk); check("t6_aw_only", awready, 0);
    read_check("t6_no_write_aw", A_START1, 1);
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b1;
    @(negedge clk); check("t6_w_only", wready, 0);
    read_check("t6_no_write_w", A_START1, 1);
    @(posedge clk); #1; awvalid = 1'b1;
    @(negedge clk); check("t6_both", wready, 1);
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
    cycles(2);
    read_check("t6_split_write", A_START1, 32'h55);
    axi_write(A_PERIOD, 32'hAABBCCDD, 4'b0001);
    read_check("t6_wstrb", A_PERIOD, 32'hDD);
    check("t6_rresp", rresp, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
